egress_frame_reader: RTL
========================

Name: egress_frame_reader

Overview:
- Downstream consumer of the frame buffer FIFO. Accepts frame descriptors (start pointer, length, drop flag) from the switch FSM.
- Per descriptor, either streams the frame's 16-bit words out as an AXI-stream-style egress packet with tlast, or discards the frame by advancing the buffer read pointer.
- Drives the buffer's frame_ren / frame_rrst / frame_rst_rptr interface and absorbs the 1-cycle RAM read latency behind a 2-entry skid buffer, so egress backpressure never loses data.

Parameters:
ADDR_WIDTH, 11, frame buffer address width; pointers and lengths are ADDR_WIDTH+1 bits.
MAX_FRAME_WORDS, 759, largest legal descriptor length in 16-bit words; longer lengths are treated as drop.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
desc_valid  input  1  descriptor offered
desc_ready  output  1  descriptor accepted when valid&ready
desc_start_ptr  input  ADDR_WIDTH+1  buffer pointer of first frame word
desc_len  input  ADDR_WIDTH+1  frame length in words
desc_drop  input  1  discard frame without emitting
frame_ren  output  1  read enable to frame buffer
frame_rrst  output  1  load buffer read pointer from frame_rst_rptr
frame_rst_rptr  output  ADDR_WIDTH+1  read pointer load value
frame_rptr  input  ADDR_WIDTH+1  current buffer read pointer
frame_rdata  input  20  buffer read data, valid 1 cycle after frame_ren
last_entry  input  1  buffer holds exactly one unread word
egress_tdata  output  16  egress word
egress_tvalid  output  1  egress word valid
egress_tlast  output  1  final word of frame
egress_tready  input  1  egress sink ready
busy  output  1  descriptor in progress

Behaviour:
- Reset: state IDLE, desc_ready=1, frame_ren=0, frame_rrst=0, frame_rst_rptr=0, egress_tvalid=0, egress_tlast=0, egress_tdata=0, busy=0, skid buffer empty, counters 0.
- FSM states: IDLE, LOAD, STREAM, DRAIN, SKIP.
- IDLE: desc_ready=1. On accept, latch start, len, drop; go to LOAD if drop=0, 1<=len<=MAX_FRAME_WORDS; otherwise go to SKIP.
- LOAD (1 cycle): frame_rrst=1, frame_rst_rptr=start; remaining=len; go to STREAM.
- STREAM: assert frame_ren when remaining>0 and (in-flight reads + skid occupancy) < 2. Each ren decrements remaining; read data enters the skid buffer the next cycle. Move to DRAIN when remaining reaches 0.
- DRAIN: wait until the skid buffer is empty and no read is in flight; go to IDLE.
- SKIP (1 cycle): frame_rrst=1, frame_rst_rptr=start+len, with modulo 2^(ADDR_WIDTH+1) wrap; go to IDLE. No egress output.
- Skid buffer output: egress_tdata=frame_rdata[15:0]. A word transfers on tvalid&tready. tvalid never deasserts, and tdata/tlast never change, while tready=0.
- tlast is set on exactly the word produced by the final ren of the descriptor.
- desc_ready=0 in every state except IDLE. busy = state!=IDLE.
- Pointer arithmetic is unsigned ADDR_WIDTH+1 bits with natural wrap; a frame crossing the buffer end streams seamlessly.
- Underflow: if frame_ren would be asserted while the buffer is empty (last_entry=0 and frame_rptr equals the word already read), ren is suppressed until data is available. Descriptors always reference fully written frames, so this case is defensive only.
- Simultaneous events: the IDLE accept and DRAIN completion never share a cycle. The next descriptor is accepted at earliest the cycle after returning to IDLE.
- Throughput: 1 word/cycle sustained with tready=1. First egress_tvalid appears 3 cycles after the accept cycle: LOAD, ren, data.
- Reset mid-frame: all state and skid contents are discarded at the next edge and the outputs return to reset values. No partial tlast is emitted.

Optional Feature:
- Macro: EGRESS_STATS_EN.
- With the macro defined:
  - Adds outputs stat_frames_sent[31:0], stat_frames_dropped[31:0], stat_words_sent[31:0].
  - Each is a saturating counter, cleared by reset.
  - frames_sent increments on the tlast transfer; words_sent increments on each transfer; frames_dropped increments on entry to SKIP.
- Without the macro: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package (packet_filter.svh): frame descriptor struct (start_ptr, len, drop); egress FSM state enum; MAX_FRAME_WORDS default constant.
- One sub-module: egress_skid_buffer (2-entry, 17-bit data+last, valid/ready on both sides, reports occupancy).

Test Plan:
- Single frame: desc start=0, len=32, drop=0, tready=1 -> rrst pulse with rst_rptr=0; 32 words match buffer contents in order; tlast on word 32 only; first tvalid 3 cycles after accept.
- Backpressure: len=8 with tready toggling 1,0,0,1... -> all 8 words delivered exactly once; tdata stable while tready=0; no extra frame_ren beyond 8.
- Drop: start=100, len=64, drop=1 -> no tvalid; one-cycle rrst with rst_rptr=164; desc_ready back high 2 cycles after accept; stat_frames_dropped=1 (EGRESS_STATS_EN).
- Wrap-around: ADDR_WIDTH=11, start=4090, len=10 -> ren reads 4090..4095 then 0..3; 10 words out; tlast on the 10th.
- Illegal lengths: len=0, then len=MAX_FRAME_WORDS+1 -> each handled as SKIP with rst_rptr=start+len; no egress output.
- Reset mid-frame: assert reset after 5 of 20 words -> next cycle tvalid=0, busy=0, desc_ready=1; a subsequent desc len=4 streams correctly.

Source files
------------

// File: rtl/egress_frame_reader_pkg.sv
// Shared types and defaults for the egress frame reader: descriptor layout,
// reader FSM state encoding and the default frame geometry.
package egress_frame_reader_pkg;

    localparam int DEF_ADDR_WIDTH      = 11;
    localparam int DEF_MAX_FRAME_WORDS = 759;
    localparam int DESC_PTR_W          = 16;
    localparam int SKID_W              = 17;

    // Fields are sized for the widest supported pointer; the reader truncates to ADDR_WIDTH+1.
    typedef struct packed {
        logic [DESC_PTR_W-1:0] start_ptr;
        logic [DESC_PTR_W-1:0] len;
        logic                  drop;
    } frame_desc_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_DRAIN,
        ST_SKIP
    } egress_state_t;

    function automatic logic len_is_legal(input logic [DESC_PTR_W-1:0] len,
                                          input logic [DESC_PTR_W-1:0] max_len);
        return (len != '0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/egress_frame_reader_skid_buffer.sv
// Two-entry skid FIFO with bypass when empty, so a word arriving from the RAM
// can be presented on the same cycle it lands.
module egress_skid_buffer #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_in_valid,
    input  logic [W-1:0] i_in_data,
    output logic         o_in_ready,
    output logic         o_out_valid,
    output logic [W-1:0] o_out_data,
    input  logic         i_out_ready,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;
    logic         w_bypass;
    logic         w_wr_ptr;

    assign o_in_ready  = (r_count != 2'd2);
    assign w_push      = i_in_valid && o_in_ready;
    assign o_out_valid = (r_count != 2'd0) || i_in_valid;
    assign o_out_data  = (r_count != 2'd0) ? r_mem[r_rd_ptr] : i_in_data;
    assign w_pop       = o_out_valid && i_out_ready;
    assign w_bypass    = w_push && w_pop && (r_count == 2'd0);
    assign w_wr_ptr    = r_rd_ptr ^ r_count[0];
    assign o_count     = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
        end else begin
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
            if (w_pop && (r_count != 2'd0))
                r_rd_ptr <= ~r_rd_ptr;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push && !w_bypass)
            r_mem[w_wr_ptr] <= i_in_data;
    end

endmodule

// File: rtl/egress_frame_reader.sv
// Frame buffer egress reader: streams or discards one descriptor at a time.
// Optional statistics counters are built when EGRESS_STATS_EN is defined.
module egress_frame_reader
    import egress_frame_reader_pkg::*;
#(
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int MAX_FRAME_WORDS = DEF_MAX_FRAME_WORDS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  desc_valid,
    output logic                  desc_ready,
    input  logic [ADDR_WIDTH:0]   desc_start_ptr,
    input  logic [ADDR_WIDTH:0]   desc_len,
    input  logic                  desc_drop,
    output logic                  frame_ren,
    output logic                  frame_rrst,
    output logic [ADDR_WIDTH:0]   frame_rst_rptr,
    input  logic [ADDR_WIDTH:0]   frame_rptr,
    input  logic [19:0]           frame_rdata,
    input  logic                  last_entry,
    output logic [15:0]           egress_tdata,
    output logic                  egress_tvalid,
    output logic                  egress_tlast,
    input  logic                  egress_tready,
    output logic                  busy
`ifdef EGRESS_STATS_EN
    ,
    output logic [31:0]           stat_frames_sent,
    output logic [31:0]           stat_frames_dropped,
    output logic [31:0]           stat_words_sent
`endif
);

    localparam int PW = ADDR_WIDTH + 1;

    egress_state_t      r_state;
    egress_state_t      w_state_nxt;
    frame_desc_t        r_desc;
    logic [PW-1:0]      r_remaining;
    logic               r_rd_pending;
    logic               r_rd_last;
    logic [PW-1:0]      r_prev_rptr;
    logic               r_prev_valid;

    logic [PW-1:0]      w_start;
    logic [PW-1:0]      w_len;
    logic               w_accept;
    logic               w_legal;
    logic               w_ren;
    logic               w_pop;
    logic               w_underflow;
    logic [2:0]         w_occ;
    logic [1:0]         w_skid_count;
    logic               w_skid_in_ready;
    logic               w_out_valid;
    logic [SKID_W-1:0]  w_out_data;
    logic               w_unused;

    assign w_start  = r_desc.start_ptr[PW-1:0];
    assign w_len    = r_desc.len[PW-1:0];
    assign w_accept = desc_valid && desc_ready;
    assign w_legal  = !desc_drop &&
                      len_is_legal(DESC_PTR_W'(desc_len), DESC_PTR_W'(MAX_FRAME_WORDS));
    assign w_pop    = w_out_valid && egress_tready;

    // Slots committed after this edge if no new read is issued; a same-cycle pop frees one.
    assign w_occ = 3'(w_skid_count) + 3'(r_rd_pending) - 3'(w_pop);

    // Read pointer failed to advance since the last read and no word is waiting.
    assign w_underflow = r_prev_valid && !last_entry && (frame_rptr == r_prev_rptr);

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        desc_ready     = 1'b0;
        busy           = 1'b1;
        frame_rrst     = 1'b0;
        frame_rst_rptr = '0;
        w_ren          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                desc_ready = 1'b1;
                busy       = 1'b0;
                if (desc_valid)
                    w_state_nxt = w_legal ? ST_LOAD : ST_SKIP;
            end
            ST_LOAD: begin
                frame_rrst     = 1'b1;
                frame_rst_rptr = w_start;
                w_state_nxt    = ST_STREAM;
            end
            ST_STREAM: begin
                if ((r_remaining != '0) && (w_occ < 3'd2) && !w_underflow) begin
                    w_ren = 1'b1;
                    if (r_remaining == PW'(1))
                        w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((w_skid_count == 2'd0) && !r_rd_pending)
                    w_state_nxt = ST_IDLE;
            end
            ST_SKIP: begin
                frame_rrst     = 1'b1;
                frame_rst_rptr = w_start + w_len;
                w_state_nxt    = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign frame_ren = w_ren;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_desc       <= '0;
            r_remaining  <= '0;
            r_rd_pending <= 1'b0;
            r_rd_last    <= 1'b0;
            r_prev_rptr  <= '0;
            r_prev_valid <= 1'b0;
        end else begin
            if (w_accept)
                r_desc <= '{start_ptr: DESC_PTR_W'(desc_start_ptr),
                            len:       DESC_PTR_W'(desc_len),
                            drop:      desc_drop};
            r_rd_pending <= w_ren;
            r_rd_last    <= w_ren && (r_remaining == PW'(1));
            if (r_state == ST_LOAD) begin
                r_remaining  <= w_len;
                r_prev_valid <= 1'b0;
            end else if (w_ren) begin
                r_remaining  <= r_remaining - PW'(1);
                r_prev_rptr  <= frame_rptr;
                r_prev_valid <= 1'b1;
            end
        end
    end

    egress_skid_buffer #(
        .W (SKID_W)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .i_in_valid  (r_rd_pending),
        .i_in_data   ({r_rd_last, frame_rdata[15:0]}),
        .o_in_ready  (w_skid_in_ready),
        .o_out_valid (w_out_valid),
        .o_out_data  (w_out_data),
        .i_out_ready (egress_tready),
        .o_count     (w_skid_count)
    );

    // Empty skid bypasses raw RAM data, so hold the bus at zero when idle.
    assign egress_tvalid = w_out_valid;
    assign egress_tdata  = w_out_valid ? w_out_data[15:0] : 16'd0;
    assign egress_tlast  = w_out_valid && w_out_data[16];

    assign w_unused = &{1'b0, frame_rdata[19:16], r_desc.start_ptr[DESC_PTR_W-1:PW],
                        r_desc.len[DESC_PTR_W-1:PW], r_desc.drop, w_skid_in_ready};

`ifdef EGRESS_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_frames_sent    <= '0;
            stat_frames_dropped <= '0;
            stat_words_sent     <= '0;
        end else begin
            if (w_pop && w_out_data[16] && (stat_frames_sent != '1))
                stat_frames_sent <= stat_frames_sent + 32'd1;
            if (w_pop && (stat_words_sent != '1))
                stat_words_sent <= stat_words_sent + 32'd1;
            if ((r_state == ST_SKIP) && (stat_frames_dropped != '1))
                stat_frames_dropped <= stat_frames_dropped + 32'd1;
        end
    end
`endif

endmodule
